// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - direction codes, FSM state codes and screen/segment defaults
package snake_pkg;

  localparam logic [1:0] DIR_RIGHT = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_UP    = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_CALC  = 3'd2;
  localparam logic [2:0] ST_OFFER = 3'd3;
  localparam logic [2:0] ST_DEAD  = 3'd4;

  localparam int XSCREEN_DEF = 160;
  localparam int YSCREEN_DEF = 120;
  localparam int XDIM_DEF    = 10;
  localparam int YDIM_DEF    = 10;
  localparam int X0_DEF      = 80;
  localparam int Y0_DEF      = 60;

  // The encoding pairs each direction with its bitwise complement as the reverse.
  function automatic logic [1:0] opposite(input logic [1:0] d);
    return ~d;
  endfunction

endpackage

// File: rtl/snake_head_stepper_if.sv
// rtl/snake_head_stepper_if.sv - step offer handshake toward the draw/shift stage
interface snake_head_stepper_if;

  logic       step_valid;
  logic       step_ready;
  logic [7:0] next_x;
  logic [6:0] next_y;

  modport master (output step_valid, output next_x, output next_y, input step_ready);
  modport slave  (input step_valid, input next_x, input next_y, output step_ready);

endinterface

// File: rtl/snake_head_stepper_key_sync.sv
// rtl/snake_head_stepper_key_sync.sv - 4-bit two-flop synchronizer for raw active-low keys
module key_sync (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic [3:0] key_n,
  output logic [3:0] keys_n
);

  logic [3:0] meta_n;

  // Reset to all-ones so every key reads as released.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      meta_n <= 4'hF;
      keys_n <= 4'hF;
    end else begin
      meta_n <= key_n;
      keys_n <= meta_n;
    end
  end

endmodule

// File: rtl/snake_head_stepper.sv
// rtl/snake_head_stepper.sv - snake head position stepper with key steering and wall detection
module snake_head_stepper
  import snake_pkg::*;
#(
  parameter int XSCREEN = XSCREEN_DEF,
  parameter int YSCREEN = YSCREEN_DEF,
  parameter int XDIM    = XDIM_DEF,
  parameter int YDIM    = YDIM_DEF,
  parameter int X0      = X0_DEF,
  parameter int Y0      = Y0_DEF
) (
  input  logic                        Clock,
  input  logic                        Resetn,
  input  logic [3:0]                  key_n,
  input  logic                        run,
  input  logic                        tick,
  snake_head_stepper_if.master        step,
  output logic [7:0]                  head_x,
  output logic [6:0]                  head_y,
  output logic [1:0]                  dir,
  output logic                        hit_wall
);

  localparam logic [8:0] X_STEP = 9'(XDIM);
  localparam logic [8:0] Y_STEP = 9'(YDIM);
  localparam logic [8:0] X_MAX  = 9'(XSCREEN - XDIM);
  localparam logic [8:0] Y_MAX  = 9'(YSCREEN - YDIM);

  logic [2:0] state;
  logic [3:0] keys_n;
  logic [1:0] pending_dir;
  logic [1:0] req_dir;
  logic       req_any;
  logic [7:0] next_x;
  logic [6:0] next_y;
  logic [8:0] cand_x;
  logic [8:0] cand_y;
  logic       out_of_range;

  key_sync u_key_sync (
    .Clock  (Clock),
    .Resetn (Resetn),
    .key_n  (key_n),
    .keys_n (keys_n)
  );

  always_comb begin
    req_any = 1'b1;
    req_dir = DIR_RIGHT;
    if      (!keys_n[0]) req_dir = DIR_RIGHT;
    else if (!keys_n[1]) req_dir = DIR_DOWN;
    else if (!keys_n[2]) req_dir = DIR_UP;
    else if (!keys_n[3]) req_dir = DIR_LEFT;
    else                 req_any = 1'b0;
  end

  // Underflow is caught before subtracting, so a wrapped candidate is never used.
  always_comb begin
    cand_x       = {1'b0, head_x};
    cand_y       = {2'b00, head_y};
    out_of_range = 1'b0;
    case (pending_dir)
      DIR_RIGHT: begin
        cand_x       = {1'b0, head_x} + X_STEP;
        out_of_range = cand_x > X_MAX;
      end
      DIR_LEFT: begin
        out_of_range = {1'b0, head_x} < X_STEP;
        cand_x       = {1'b0, head_x} - X_STEP;
      end
      DIR_DOWN: begin
        cand_y       = {2'b00, head_y} + Y_STEP;
        out_of_range = cand_y > Y_MAX;
      end
      default: begin
        out_of_range = {2'b00, head_y} < Y_STEP;
        cand_y       = {2'b00, head_y} - Y_STEP;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state       <= ST_IDLE;
      head_x      <= 8'(X0);
      head_y      <= 7'(Y0);
      next_x      <= 8'(X0);
      next_y      <= 7'(Y0);
      dir         <= DIR_RIGHT;
      pending_dir <= DIR_RIGHT;
      hit_wall    <= 1'b0;
    end else begin
      if (state != ST_DEAD && req_any && req_dir != opposite(dir))
        pending_dir <= req_dir;
      case (state)
        ST_IDLE: if (run) state <= ST_WAIT;
        ST_WAIT: begin
          if (!run)      state <= ST_IDLE;
          else if (tick) state <= ST_CALC;
        end
        ST_CALC: begin
          if (out_of_range) begin
            hit_wall <= 1'b1;
            state    <= ST_DEAD;
          end else begin
            next_x <= cand_x[7:0];
            next_y <= cand_y[6:0];
            state  <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (step.step_ready) begin
            head_x <= next_x;
            head_y <= next_y;
            dir    <= pending_dir;
            state  <= ST_WAIT;
          end
        end
        ST_DEAD: state <= ST_DEAD;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign step.step_valid = (state == ST_OFFER);
  assign step.next_x     = next_x;
  assign step.next_y     = next_y;

endmodule

// File: tb/tb_snake_head_stepper.sv
// tb/tb_snake_head_stepper.sv - self-checking bench for snake_head_stepper
module tb_snake_head_stepper;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic [3:0] key_n;
  logic       run;
  logic       tick;
  logic [7:0] head_x;
  logic [6:0] head_y;
  logic [1:0] dir;
  logic       hit_wall;

  int errors = 0;
  int checks = 0;

  snake_head_stepper_if sif ();

  always #5 Clock = ~Clock;

  snake_head_stepper dut (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .key_n    (key_n),
    .run      (run),
    .tick     (tick),
    .step     (sif),
    .head_x   (head_x),
    .head_y   (head_y),
    .dir      (dir),
    .hit_wall (hit_wall)
  );

  typedef struct {
    logic [3:0] keys;
    int         exp_x;
    int         exp_y;
    int         exp_dir;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic do_reset();
    Resetn         = 1'b0;
    key_n          = 4'hF;
    run            = 1'b0;
    tick           = 1'b0;
    sif.step_ready = 1'b0;
    cyc(2);
    Resetn = 1'b1;
    cyc(1);
  endtask

  task automatic set_keys(input logic [3:0] k);
    key_n = k;
    cyc(4);
    key_n = 4'hF;
    cyc(4);
  endtask

  task automatic fire_tick();
    run = 1'b1;
    cyc(1);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
  endtask

  task automatic wait_valid(output bit got);
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (sif.step_valid) begin
        got = 1'b1;
        break;
      end
      cyc(1);
    end
  endtask

  task automatic handshake();
    sif.step_ready = 1'b1;
    cyc(1);
    sif.step_ready = 1'b0;
  endtask

  task automatic step_once(input string name, input int ex, input int ey, input int ed);
    bit got;
    fire_tick();
    wait_valid(got);
    chk({name, "_valid"}, int'(got), 1);
    chk({name, "_next_x"}, int'(sif.next_x), ex);
    chk({name, "_next_y"}, int'(sif.next_y), ey);
    handshake();
    chk({name, "_head_x"}, int'(head_x), ex);
    chk({name, "_head_y"}, int'(head_y), ey);
    chk({name, "_dir"}, int'(dir), ed);
    chk({name, "_valid_low"}, int'(sif.step_valid), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    bit   got;
    int   mhx, mhy, mdir, mpend, nx, ny, req;
    logic [3:0] k;

    vecs[0] = '{4'b1111, 90, 60, 0};
    vecs[1] = '{4'b1110, 90, 60, 0};
    vecs[2] = '{4'b1101, 80, 70, 1};
    vecs[3] = '{4'b1011, 80, 50, 2};
    vecs[4] = '{4'b0111, 90, 60, 0};
    vecs[5] = '{4'b0110, 90, 60, 0};
    vecs[6] = '{4'b1001, 80, 70, 1};
    vecs[7] = '{4'b0011, 80, 50, 2};
    vecs[8] = '{4'b0000, 90, 60, 0};

    do_reset();
    chk("rst_valid", int'(sif.step_valid), 0);
    chk("rst_head_x", int'(head_x), 80);
    chk("rst_head_y", int'(head_y), 60);
    chk("rst_next_x", int'(sif.next_x), 80);
    chk("rst_next_y", int'(sif.next_y), 60);
    chk("rst_dir", int'(dir), 0);
    chk("rst_hit_wall", int'(hit_wall), 0);

    for (int i = 0; i < 9; i++) begin
      do_reset();
      set_keys(vecs[i].keys);
      step_once($sformatf("vec%0d", i), vecs[i].exp_x, vecs[i].exp_y, vecs[i].exp_dir);
    end

    // Tick-to-offer latency: two clock edges.
    do_reset();
    run = 1'b1;
    cyc(1);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    chk("lat_calc_valid", int'(sif.step_valid), 0);
    cyc(1);
    chk("lat_offer_valid", int'(sif.step_valid), 1);
    chk("lat_next_x", int'(sif.next_x), 90);
    chk("lat_next_y", int'(sif.next_y), 60);
    handshake();
    chk("lat_head_x", int'(head_x), 90);

    // Down, then right+left together while heading down.
    do_reset();
    set_keys(4'b1101);
    step_once("down", 80, 70, 1);
    set_keys(4'b0110);
    step_once("right_wins", 90, 70, 0);

    // Stalled offer with extra ticks.
    do_reset();
    fire_tick();
    wait_valid(got);
    chk("stall_valid", int'(got), 1);
    for (int i = 0; i < 5; i++) begin
      tick = (i == 1 || i == 3);
      cyc(1);
      chk("stall_hold_valid", int'(sif.step_valid), 1);
      chk("stall_hold_next_x", int'(sif.next_x), 90);
      chk("stall_hold_next_y", int'(sif.next_y), 60);
      chk("stall_hold_head_x", int'(head_x), 80);
    end
    tick = 1'b0;
    handshake();
    chk("stall_commit_x", int'(head_x), 90);
    cyc(6);
    chk("stall_no_extra_valid", int'(sif.step_valid), 0);
    chk("stall_no_extra_x", int'(head_x), 90);

    // run dropping mid-offer does not withdraw it.
    do_reset();
    fire_tick();
    wait_valid(got);
    run = 1'b0;
    cyc(2);
    chk("runlow_valid_kept", int'(sif.step_valid), 1);
    handshake();
    chk("runlow_commit_x", int'(head_x), 90);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    cyc(4);
    chk("runlow_idle_valid", int'(sif.step_valid), 0);
    chk("runlow_idle_x", int'(head_x), 90);

    // Right wall: 80 -> 150, then one more step dies.
    do_reset();
    for (int i = 1; i <= 7; i++) step_once($sformatf("rw%0d", i), 80 + 10 * i, 60, 0);
    fire_tick();
    cyc(3);
    chk("rwall_hit", int'(hit_wall), 1);
    chk("rwall_valid", int'(sif.step_valid), 0);
    key_n = 4'b1101;
    got   = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick = i[0];
      run  = (i < 6);
      cyc(1);
      if (sif.step_valid) got = 1'b1;
    end
    tick  = 1'b0;
    key_n = 4'hF;
    chk("dead_never_valid", int'(got), 0);
    chk("dead_head_x", int'(head_x), 150);
    chk("dead_head_y", int'(head_y), 60);
    chk("dead_dir", int'(dir), 0);
    chk("dead_hit_sticky", int'(hit_wall), 1);

    // Top wall: 60 -> 0 going up, then underflow dies.
    do_reset();
    set_keys(4'b1011);
    for (int i = 1; i <= 6; i++) step_once($sformatf("uw%0d", i), 80, 60 - 10 * i, 2);
    fire_tick();
    cyc(3);
    chk("uwall_hit", int'(hit_wall), 1);
    chk("uwall_head_y", int'(head_y), 0);

    // Asynchronous reset while an offer is pending.
    do_reset();
    set_keys(4'b1101);
    step_once("pre_areset", 80, 70, 1);
    fire_tick();
    wait_valid(got);
    chk("areset_pre_valid", int'(sif.step_valid), 1);
    #2;
    Resetn = 1'b0;
    #1;
    chk("areset_valid", int'(sif.step_valid), 0);
    chk("areset_head_x", int'(head_x), 80);
    chk("areset_head_y", int'(head_y), 60);
    chk("areset_dir", int'(dir), 0);
    @(negedge Clock);
    Resetn = 1'b1;
    run    = 1'b0;
    cyc(1);

    // Random walk against a transaction-level model.
    do_reset();
    mhx = 80; mhy = 60; mdir = 0; mpend = 0;
    for (int it = 0; it < 60; it++) begin
      k = 4'($urandom_range(0, 15));
      req = -1;
      for (int b = 3; b >= 0; b--) if (!k[b]) req = b;
      if (req >= 0 && req != 3 - mdir) mpend = req;
      set_keys(k);
      nx = mhx + (mpend == 0 ? 10 : (mpend == 3 ? -10 : 0));
      ny = mhy + (mpend == 1 ? 10 : (mpend == 2 ? -10 : 0));
      fire_tick();
      if (nx < 0 || nx > 150 || ny < 0 || ny > 110) begin
        cyc(3);
        chk("rnd_wall_hit", int'(hit_wall), 1);
        chk("rnd_wall_valid", int'(sif.step_valid), 0);
        do_reset();
        mhx = 80; mhy = 60; mdir = 0; mpend = 0;
      end else begin
        wait_valid(got);
        chk("rnd_valid", int'(got), 1);
        cyc($urandom_range(0, 3));
        chk("rnd_next_x", int'(sif.next_x), nx);
        chk("rnd_next_y", int'(sif.next_y), ny);
        handshake();
        mhx = nx; mhy = ny; mdir = mpend;
        chk("rnd_head_x", int'(head_x), mhx);
        chk("rnd_head_y", int'(head_y), mhy);
        chk("rnd_dir", int'(dir), mdir);
        chk("rnd_hit_clear", int'(hit_wall), 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
